// File: rtl/irq_trap_sequencer.sv
// Machine-mode interrupt entry / MRET sequencer: waits for a stall-free boundary, then flushes,
// kills EX, redirects the PC and strobes the CSR trap/return updates. Option: VECTORED_IRQ_EN.
module irq_trap_sequencer #(
  parameter int XLEN       = 32,
  parameter int MCAUSE_EXT = 11,
  parameter int MCAUSE_SW  = 3,
  parameter int MCAUSE_TMR = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            irq_ext,
  input  logic            irq_sw,
  input  logic            irq_timer,
  input  logic [2:0]      mie_en,
  input  logic            mstatus_mie,
  input  logic            mstatus_mpie,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic [XLEN-1:0] pc_ex,
  input  logic [XLEN-1:0] pc_if,
  input  logic            ex_valid,
  input  logic            br_redirect,
  input  logic [XLEN-1:0] br_target,
  input  logic            stall,
  input  logic            is_mret_ppl,
  output logic            trap_flush,
  output logic            kill_ex,
  output logic            pc_redirect,
  output logic [XLEN-1:0] pc_target,
  output logic            csr_trap_wr,
  output logic            csr_ret_wr,
  output logic [XLEN-1:0] mepc_nxt,
  output logic [XLEN-1:0] mcause_nxt,
  output logic            mstatus_mie_nxt,
  output logic            mstatus_mpie_nxt,
  output logic            busy
);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_TRAP, S_RET} state_t;

  localparam logic [XLEN-2:0] LP_CAUSE_EXT = (XLEN-1)'(MCAUSE_EXT);
  localparam logic [XLEN-2:0] LP_CAUSE_SW  = (XLEN-1)'(MCAUSE_SW);
  localparam logic [XLEN-2:0] LP_CAUSE_TMR = (XLEN-1)'(MCAUSE_TMR);

  state_t          r_state, w_state_nxt;
  logic [XLEN-2:0] r_cause, w_cause;
  logic [XLEN-1:0] r_epc, w_epc, w_base, w_trap_tgt;
  logic            w_pending, w_capture;

  assign w_pending = mstatus_mie & (|({irq_ext, irq_sw, irq_timer} & mie_en));

  always_comb begin
    if (irq_ext & mie_en[2])     w_cause = LP_CAUSE_EXT;
    else if (irq_sw & mie_en[1]) w_cause = LP_CAUSE_SW;
    else                         w_cause = LP_CAUSE_TMR;
  end

  // EX commits on the capture edge, so the resume point is the instruction after it
  assign w_epc  = ex_valid ? (br_redirect ? br_target : pc_ex + XLEN'(4)) : pc_if;
  assign w_base = {mtvec[XLEN-1:2], 2'b00};

`ifdef VECTORED_IRQ_EN
  assign w_trap_tgt = (mtvec[1:0] == 2'b01) ? w_base + {r_cause[XLEN-3:0], 2'b00} : w_base;
  logic w_unused;
  assign w_unused = r_cause[XLEN-2];
`else
  assign w_trap_tgt = w_base;
  logic w_unused;
  assign w_unused = &{1'b0, mtvec[1:0]};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cause <= '0;
      r_epc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_cause <= w_cause;
        r_epc   <= w_epc;
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_capture        = 1'b0;
    trap_flush       = 1'b0;
    kill_ex          = 1'b0;
    pc_redirect      = 1'b0;
    pc_target        = '0;
    csr_trap_wr      = 1'b0;
    csr_ret_wr       = 1'b0;
    mepc_nxt         = '0;
    mcause_nxt       = '0;
    mstatus_mie_nxt  = 1'b0;
    mstatus_mpie_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (is_mret_ppl & ~stall) begin
          w_state_nxt = S_RET;
        end else if (w_pending & ~stall) begin
          w_state_nxt = S_TRAP;
          w_capture   = 1'b1;
        end else if (w_pending) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!w_pending) begin
          w_state_nxt = S_IDLE;
        end else if (!stall) begin
          w_state_nxt = S_TRAP;
          w_capture   = 1'b1;
        end
      end
      S_TRAP: begin
        w_state_nxt      = S_IDLE;
        trap_flush       = 1'b1;
        kill_ex          = 1'b1;
        pc_redirect      = 1'b1;
        csr_trap_wr      = 1'b1;
        pc_target        = w_trap_tgt;
        mepc_nxt         = r_epc;
        mcause_nxt       = {1'b1, r_cause};
        mstatus_mpie_nxt = 1'b1;
      end
      S_RET: begin
        w_state_nxt      = S_IDLE;
        trap_flush       = 1'b1;
        kill_ex          = 1'b1;
        pc_redirect      = 1'b1;
        csr_ret_wr       = 1'b1;
        pc_target        = mepc;
        mstatus_mie_nxt  = mstatus_mpie;
        mstatus_mpie_nxt = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_irq_trap_sequencer.sv
// Self-checking bench for irq_trap_sequencer: directed scenarios with literal expectations,
// then randomized stimulus checked every cycle against a behavioural model.
module tb_irq_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        irq_ext, irq_sw, irq_timer;
  logic [2:0]  mie_en;
  logic        mstatus_mie, mstatus_mpie;
  logic [31:0] mtvec, mepc, pc_ex, pc_if, br_target;
  logic        ex_valid, br_redirect, stall, is_mret_ppl;
  logic        trap_flush, kill_ex, pc_redirect, csr_trap_wr, csr_ret_wr;
  logic [31:0] pc_target, mepc_nxt, mcause_nxt;
  logic        mstatus_mie_nxt, mstatus_mpie_nxt, busy;

  irq_trap_sequencer #(.XLEN(32), .MCAUSE_EXT(11), .MCAUSE_SW(3), .MCAUSE_TMR(7)) dut (
    .clk(clk), .rst(rst), .irq_ext(irq_ext), .irq_sw(irq_sw), .irq_timer(irq_timer),
    .mie_en(mie_en), .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie),
    .mtvec(mtvec), .mepc(mepc), .pc_ex(pc_ex), .pc_if(pc_if), .ex_valid(ex_valid),
    .br_redirect(br_redirect), .br_target(br_target), .stall(stall), .is_mret_ppl(is_mret_ppl),
    .trap_flush(trap_flush), .kill_ex(kill_ex), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .csr_trap_wr(csr_trap_wr), .csr_ret_wr(csr_ret_wr), .mepc_nxt(mepc_nxt),
    .mcause_nxt(mcause_nxt), .mstatus_mie_nxt(mstatus_mie_nxt),
    .mstatus_mpie_nxt(mstatus_mpie_nxt), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // m_act: what the sequencer is doing this cycle (0 nothing, 1 trap entry, 2 mret)
  // m_wait: an interrupt is being held off behind a stall
  int          m_act;
  bit          m_wait;
  logic [31:0] m_epc;
  int          m_cause;

  function automatic bit pend();
    return mstatus_mie && ((irq_ext && mie_en[2]) || (irq_sw && mie_en[1]) || (irq_timer && mie_en[0]));
  endfunction

  function automatic int src_cause();
    if (irq_ext && mie_en[2]) return 11;
    if (irq_sw && mie_en[1])  return 3;
    return 7;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_act <= 0; m_wait <= 1'b0; m_epc <= '0; m_cause <= 0;
    end else if (m_act != 0) begin
      m_act <= 0; m_wait <= 1'b0;
    end else if (!m_wait && is_mret_ppl && !stall) begin
      m_act <= 2;
    end else if (pend() && !stall) begin
      m_act   <= 1;
      m_wait  <= 1'b0;
      m_cause <= src_cause();
      m_epc   <= ex_valid ? (br_redirect ? br_target : pc_ex + 32'd4) : pc_if;
    end else begin
      m_wait <= pend();
    end
  end

  // Compare process: outputs sampled on the falling edge against the model
  always @(negedge clk) begin
    logic [7:0]  e_ctl, a_ctl;
    logic [31:0] e_tgt, e_mepc, e_mcause;
    e_ctl = 8'h00; e_tgt = '0; e_mepc = '0; e_mcause = '0;
    if (m_act == 1) begin
      e_tgt = {mtvec[31:2], 2'b00};
`ifdef VECTORED_IRQ_EN
      if (mtvec[1:0] == 2'b01) e_tgt = e_tgt + 32'(4 * m_cause);
`endif
      e_mepc   = m_epc;
      e_mcause = 32'h8000_0000 | 32'(m_cause);
      e_ctl    = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    end else if (m_act == 2) begin
      e_tgt = mepc;
      e_ctl = {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, mstatus_mpie, 1'b1, 1'b1};
    end else begin
      e_ctl = {7'b0, m_wait};
    end
    a_ctl = {trap_flush, kill_ex, pc_redirect, csr_trap_wr, csr_ret_wr,
             mstatus_mie_nxt, mstatus_mpie_nxt, busy};
    chk("model_ctl", {24'h0, a_ctl}, {24'h0, e_ctl});
    chk("model_pc_target", pc_target, e_tgt);
    chk("model_mepc_nxt", mepc_nxt, e_mepc);
    chk("model_mcause_nxt", mcause_nxt, e_mcause);
  end

  // ---------------- stimulus ----------------
  task automatic clear_inputs();
    irq_ext = 0; irq_sw = 0; irq_timer = 0; mie_en = 3'b000;
    mstatus_mie = 0; mstatus_mpie = 0; mtvec = '0; mepc = '0;
    pc_ex = '0; pc_if = '0; br_target = '0; ex_valid = 0; br_redirect = 0;
    stall = 0; is_mret_ppl = 0;
  endtask

  task automatic drive_gap();
    @(negedge clk);
    #1;
  endtask

  function automatic bit rnd_pct(input int pct);
    return ($urandom_range(99) < pct);
  endfunction

  initial begin
    clear_inputs();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_strobes", {27'h0, trap_flush, kill_ex, pc_redirect, csr_trap_wr, csr_ret_wr}, 32'h0);
    #1 rst = 1'b1;

    // Direct entry on the timer interrupt
    drive_gap();
    mtvec = 32'h100; mstatus_mie = 1; mie_en = 3'b001; irq_timer = 1;
    ex_valid = 1; pc_ex = 32'h40; pc_if = 32'h48;
    @(negedge clk);
    chk("t1_trap_wr", {31'h0, csr_trap_wr}, 32'h1);
    chk("t1_pc_target", pc_target, 32'h100);
    chk("t1_mepc_nxt", mepc_nxt, 32'h44);
    chk("t1_mcause_nxt", mcause_nxt, 32'h8000_0007);
    chk("t1_mie_nxt", {31'h0, mstatus_mie_nxt}, 32'h0);
    #1 irq_timer = 0; mstatus_mie = 0;
    @(negedge clk);
    chk("t1_back_idle", {31'h0, busy}, 32'h0);

    // Priority with a 3-cycle stall, branch in flight at the capture edge
    #1 mstatus_mie = 1; mie_en = 3'b111; irq_ext = 1; irq_timer = 1; stall = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_drain_busy", {31'h0, busy}, 32'h1);
      chk("t2_drain_no_strobe", {30'h0, csr_trap_wr, pc_redirect}, 32'h0);
    end
    #1 stall = 0; br_redirect = 1; br_target = 32'h200;
    @(negedge clk);
    chk("t2_mcause_ext", mcause_nxt, 32'h8000_000B);
    chk("t3_mepc_branch", mepc_nxt, 32'h200);
    #1 irq_ext = 0; irq_timer = 0; mstatus_mie = 0; br_redirect = 0;
    @(negedge clk);

    // MRET beats a pending software interrupt, which is then taken
    #1 is_mret_ppl = 1; irq_sw = 1; mie_en = 3'b010; mstatus_mie = 1; mepc = 32'h44; mstatus_mpie = 1;
    @(negedge clk);
    chk("t4_ret_wr", {31'h0, csr_ret_wr}, 32'h1);
    chk("t4_ret_target", pc_target, 32'h44);
    chk("t4_ret_mie_nxt", {31'h0, mstatus_mie_nxt}, 32'h1);
    #1 is_mret_ppl = 0;
    @(negedge clk);
    chk("t4_idle_between", {31'h0, busy}, 32'h0);
    #1;
    @(negedge clk);
    chk("t4_trap_cause_sw", mcause_nxt, 32'h8000_0003);
    #1 irq_sw = 0; mstatus_mie = 0;

    // Global gate off: nothing happens
    drive_gap();
    irq_ext = 1; irq_sw = 1; irq_timer = 1; mie_en = 3'b111; mstatus_mie = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_gated_busy", {31'h0, busy}, 32'h0);
    end
    // Withdrawal while draining
    #1 mstatus_mie = 1; stall = 1;
    @(negedge clk);
    chk("t5_draining", {31'h0, busy}, 32'h1);
    #1 irq_ext = 0; irq_sw = 0; irq_timer = 0;
    @(negedge clk);
    chk("t5_withdrawn_idle", {31'h0, busy}, 32'h0);
    chk("t5_no_trap_wr", {31'h0, csr_trap_wr}, 32'h0);
    #1 stall = 0;

    // Timer trap with mode bits 01, then async reset in the middle of TRAP
    drive_gap();
    mtvec = 32'h101; irq_timer = 1; mie_en = 3'b001; mstatus_mie = 1;
    @(negedge clk);
`ifdef VECTORED_IRQ_EN
    chk("t6_vector_target", pc_target, 32'h11C);
`else
    chk("t6_direct_target", pc_target, 32'h100);
`endif
    #1 rst = 1'b0;
    #1;
    chk("t6_async_strobes", {27'h0, trap_flush, kill_ex, pc_redirect, csr_trap_wr, csr_ret_wr}, 32'h0);
    chk("t6_async_data", pc_target | mepc_nxt | mcause_nxt, 32'h0);
    chk("t6_async_busy", {30'h0, busy, mstatus_mpie_nxt}, 32'h0);
    clear_inputs();
    drive_gap();
    rst = 1'b1;

    // Randomized phase
    for (int c = 0; c < 4000; c++) begin
      drive_gap();
      irq_ext      = rnd_pct(25);
      irq_sw       = rnd_pct(25);
      irq_timer    = rnd_pct(30);
      mie_en       = 3'($urandom_range(7));
      mstatus_mie  = rnd_pct(70);
      mstatus_mpie = rnd_pct(50);
      mtvec        = $urandom();
      mepc         = $urandom();
      pc_ex        = (c % 97 == 0) ? 32'hFFFF_FFFC : $urandom();
      pc_if        = $urandom();
      br_target    = $urandom();
      ex_valid     = rnd_pct(80);
      br_redirect  = rnd_pct(25);
      stall        = rnd_pct(35);
      is_mret_ppl  = rnd_pct(15);
    end
    drive_gap();
    clear_inputs();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/irq_trap_sequencer.md
Name: irq_trap_sequencer

Overview:
- Machine-mode interrupt and MRET sequencer for the 3-stage pipeline.
- Watches the level interrupt lines and the MIE/MSTATUS enables, plus the pipelined mret flag from the decode controller.
- Picks a safe instruction boundary, then drives pipeline flush, execute-stage kill, PC redirect and CSR trap-state updates (mepc, mcause, mstatus).
- Sits beside the decode controller and the CSR file; its flush/redirect outputs are OR-ed into the existing flush and PC-select paths.

Parameters:
- XLEN, 32, datapath/CSR width.
- MCAUSE_EXT, 11, cause code for the machine external interrupt.
- MCAUSE_SW, 3, cause code for the machine software interrupt.
- MCAUSE_TMR, 7, cause code for the machine timer interrupt.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- irq_ext  in  1  external interrupt, level
- irq_sw  in  1  software interrupt, level
- irq_timer  in  1  timer interrupt, level
- mie_en  in  3  {MEIE, MSIE, MTIE} from the mie CSR
- mstatus_mie  in  1  current mstatus.MIE
- mstatus_mpie  in  1  current mstatus.MPIE
- mtvec  in  XLEN  trap vector CSR
- mepc  in  XLEN  current mepc CSR, used as the MRET target
- pc_ex  in  XLEN  PC of the execute-stage instruction
- pc_if  in  XLEN  PC of the fetch-stage instruction
- ex_valid  in  1  execute stage holds a real (non-bubble) instruction
- br_redirect  in  1  execute-stage instruction redirects the PC (taken branch, jal, jalr)
- br_target  in  XLEN  redirect target of the execute-stage instruction
- stall  in  1  pipeline stall (load/store in progress)
- is_mret_ppl  in  1  execute-stage instruction is MRET
- trap_flush  out  1  flush the fetch→execute pipeline register
- kill_ex  out  1  suppress reg/mem/CSR writes of the current execute-stage instruction
- pc_redirect  out  1  force PC to pc_target
- pc_target  out  XLEN  redirect address
- csr_trap_wr  out  1  write mepc, mcause and mstatus on trap entry
- csr_ret_wr  out  1  write mstatus on MRET
- mepc_nxt  out  XLEN  value for mepc
- mcause_nxt  out  XLEN  value for mcause
- mstatus_mie_nxt  out  1  new mstatus.MIE
- mstatus_mpie_nxt  out  1  new mstatus.MPIE
- busy  out  1  high whenever state != IDLE

Behaviour:
- Async reset (rst=0): state=IDLE, capture registers=0, every output=0 immediately.
- pending = mstatus_mie & ((irq_ext&MEIE) | (irq_sw&MSIE) | (irq_timer&MTIE)).
- Source priority: ext > sw > timer.
- States: IDLE, DRAIN, TRAP, RET.
- IDLE transitions:
  - is_mret_ppl & !stall → RET. MRET wins over a simultaneous pending interrupt.
  - else pending & !stall → TRAP, with capture.
  - else pending & stall → DRAIN.
  - is_mret_ppl & stall → stay in IDLE.
- DRAIN transitions:
  - !pending → IDLE (interrupt withdrawn, no trap).
  - pending & !stall → TRAP, with capture.
  - otherwise stay.
- Capture, on the clock edge entering TRAP:
  - cause_q = highest-priority enabled source.
  - The execute instruction commits on that same edge, so epc_q = ex_valid ? (br_redirect ? br_target : pc_ex+4) : pc_if.
- TRAP, exactly 1 cycle, then → IDLE:
  - trap_flush=1, kill_ex=1, pc_redirect=1, csr_trap_wr=1.
  - pc_target = {mtvec[XLEN-1:2], 2'b00}.
  - mepc_nxt = epc_q; mcause_nxt = {1'b1, cause_q zero-extended}.
  - mstatus_mie_nxt=0; mstatus_mpie_nxt=1.
- RET, exactly 1 cycle, then → IDLE:
  - trap_flush=1, kill_ex=1, pc_redirect=1, csr_ret_wr=1.
  - pc_target = mepc.
  - mstatus_mie_nxt = mstatus_mpie; mstatus_mpie_nxt=1.
- Output defaults: in IDLE and DRAIN, all strobes are 0 and the data outputs are 0.
- stall during TRAP or RET is ignored; flush and redirect take precedence over stall.
- Trap latency: exactly 1 cycle from the first cycle with pending & !stall to TRAP.
- No re-entry: mstatus.MIE reads 0 one cycle after TRAP, so the next trap needs an MRET first.
- Back-to-back: an interrupt still pending after RET (MIE restored to 1) is taken starting the next cycle.
- Arithmetic: pc_ex+4 wraps modulo 2^XLEN.

Optional Feature:
- Macro: VECTORED_IRQ_EN.
- Defined: when mtvec[1:0]==2'b01, pc_target in TRAP = {mtvec[XLEN-1:2], 2'b00} + 4*cause_q. Any other mode value behaves as direct.
- Undefined: mtvec[1:0] is ignored; all traps go to the direct base.

Test Plan:
- Direct entry: mtvec=0x100, MIE=1, MTIE=1, irq_timer=1, ex_valid=1, pc_ex=0x40, no stall → TRAP next cycle; pc_target=0x100, mepc_nxt=0x44, mcause_nxt=0x80000007, mstatus_mie_nxt=0.
- Priority plus stall drain: irq_ext=irq_timer=1, all enables set, stall=1 for 3 cycles → busy=1, no strobes for 3 cycles; TRAP the cycle after stall drops with mcause_nxt=0x8000000B.
- Branch in flight: br_redirect=1, br_target=0x200 at the capture edge → mepc_nxt=0x200.
- MRET vs interrupt: is_mret_ppl=1 with irq_sw pending, mepc=0x44, mstatus_mpie=1 → RET first (pc_target=0x44, mstatus_mie_nxt=1); then TRAP with cause 3.
- Gating and withdrawal: mstatus_mie=0 with all IRQs high → no activity. Interrupt dropped while in DRAIN → return to IDLE, no csr_trap_wr.
- Async reset asserted mid-TRAP → all outputs 0 without waiting for a clock edge. With VECTORED_IRQ_EN, mtvec=0x101 and the timer interrupt → pc_target=0x11C.
